uart_transmitter: RTL and testbench

//  Serial UART TX stage, downstream of interface_alu: takes the parallel result

---
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 tb/tb_uart_transmitter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out handshake between the ALU-side logic and the UART TX stage.
interface uart_transmitter_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_tx_data;
  logic               o_tx;
  logic               o_tx_busy;
  logic               o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_tx_data,
    input  o_tx, o_tx_busy, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_tx_data,
    output o_tx, o_tx_busy, o_tx_done
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, NB_DATA data bits LSB-first, stop bit, 16x baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input logic               i_clock,
  input logic               i_reset,
  uart_transmitter_if.slave bus
);
  localparam int              BW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [3:0]      OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      SB_LAST  = 4'(SB_TICK - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [3:0]         tick_reg, tick_next;
  logic [BW-1:0]      bit_reg, bit_next;
  logic [NB_DATA-1:0] shreg_reg, shreg_next;
  logic               tx_reg, tx_next;
  logic               done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic               parity_reg, parity_next;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      bit_reg    <= bit_next;
      shreg_reg  <= shreg_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    bit_next    = bit_reg;
    shreg_next  = shreg_reg;
    done_next   = 1'b0;
    tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.i_tx_start) begin
          shreg_next  = bus.i_tx_data;
          tick_next   = '0;
          state_next  = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^bus.i_tx_data;
`endif
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            shreg_next = shreg_reg >> 1;
            if (bit_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_reg + BW'(1);
            end
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.i_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            state_next = STOP;
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.i_tick) begin
          if (tick_reg == SB_LAST) begin
            tick_next  = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state so o_tx comes straight from a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.o_tx      = tx_reg;
  assign bus.o_tx_busy = (state_reg != IDLE);
  assign bus.o_tx_done = done_reg;
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected bytes, a monitor
// decodes the serial line at bit centres by counting baud ticks.
module tb_uart_transmitter;
  localparam int NB = 8;
  localparam int OS = 16;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (1 + NB + PAR) * OS + SB;
  localparam int DONE_LIMIT = FRAME * 6 * 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_transmitter_if #(.NB_DATA(NB)) bus ();

  uart_transmitter #(.NB_DATA(NB), .OVERSAMPLE(OS), .SB_TICK(SB)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int stray_done = 0;
  int frames_done = 0;
  int frames_expected = 0;

  // Monitor state
  bit         mon_in_frame = 1'b0;
  int         mon_n = 0;
  logic [7:0] mon_cur = 8'h00;
  bit         mon_early_done = 1'b0;
  bit         mon_busy_bad = 1'b0;

  int tick_gap = 3;

  // Line level for bit k of a frame carrying d: start, data LSB first, [parity], stop.
  function automatic logic expected_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= NB) return d[k-1];
    if (PAR != 0 && k == NB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Baud tick: single-cycle pulses with random spacing, changed on the falling edge.
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_gap == 0) begin
        bus.i_tick = 1'b1;
        tick_gap = $urandom_range(2, 5);
      end else begin
        bus.i_tick = 1'b0;
        tick_gap--;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_in_frame = 1'b0;
        check("reset_outputs", {29'd0, bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 32'b100);
      end else if (!mon_in_frame) begin
        if (bus.o_tx_done) stray_done++;
        if (bus.o_tx == 1'b0) begin
          check("frame_expected", exp_q.size() != 0, 1);
          mon_cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          mon_in_frame = 1'b1;
          mon_n = 0;
          mon_early_done = 1'b0;
          mon_busy_bad = 1'b0;
        end
      end else begin
        if (bus.i_tick) mon_n++;
        if (mon_n == FRAME) begin
          check($sformatf("done_at_end_%02h", mon_cur), bus.o_tx_done, 1);
          check($sformatf("busy_low_at_end_%02h", mon_cur), bus.o_tx_busy, 0);
          check($sformatf("early_done_%02h", mon_cur), mon_early_done, 0);
          check($sformatf("busy_drop_%02h", mon_cur), mon_busy_bad, 0);
          mon_in_frame = 1'b0;
          frames_done++;
        end else begin
          if (bus.o_tx_done) mon_early_done = 1'b1;
          if (!bus.o_tx_busy) mon_busy_bad = 1'b1;
          if (bus.i_tick && (mon_n % OS) == OS / 2)
            check($sformatf("bit%0d_of_%02h", mon_n / OS, mon_cur),
                  bus.o_tx, expected_bit(mon_cur, mon_n / OS));
        end
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.o_tx_busy && k < 5000) begin
      wait_cycle();
      k++;
    end
    check("idle_timeout", bus.o_tx_busy, 0);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    bus.i_tx_data = b;
    bus.i_tx_start = 1'b1;
    exp_q.push_back(b);
    frames_expected++;
    wait_cycle();
    bus.i_tx_start = 1'b0;
    bus.i_tx_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      wait_cycle();
      k++;
    end while (!bus.o_tx_done && k < DONE_LIMIT);
    check("done_timeout", bus.o_tx_done, 1);
  endtask

  task automatic wait_ticks(input int cnt);
    int c;
    c = 0;
    while (c < cnt) begin
      wait_cycle();
      if (bus.i_tick) c++;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h00;
    rst_n = 1'b0;

    // Reset, then a long quiet period
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20000) wait_cycle();
    check("quiet_line", bus.o_tx, 1);
    check("quiet_busy", bus.o_tx_busy, 0);

    // Single frame
    send(8'hAA);
    wait_done();

    // Start held high: two back-to-back frames
    wait_idle();
    bus.i_tx_data = 8'h0F;
    bus.i_tx_start = 1'b1;
    exp_q.push_back(8'h0F);
    frames_expected++;
    wait_cycle();
    wait_done();
    exp_q.push_back(8'h0F);
    frames_expected++;
    check("b2b_gap_line", bus.o_tx, 1);
    wait_cycle();
    check("b2b_restart_line", bus.o_tx, 0);
    check("b2b_restart_busy", bus.o_tx_busy, 1);
    bus.i_tx_start = 1'b0;
    wait_done();
    wait_cycle();
    check("held_release_idle", bus.o_tx_busy, 0);

    // Start pulse during data bit 2 must be ignored
    send(8'hAA);
    wait_ticks(3 * OS + OS / 2);
    bus.i_tx_data = 8'h55;
    bus.i_tx_start = 1'b1;
    wait_cycle();
    bus.i_tx_start = 1'b0;
    wait_done();

    // Reset in data bit 3 takes effect within the cycle and aborts the frame
    send(8'h00);
    wait_ticks(4 * OS + OS / 2);
    #2;
    rst_n = 1'b0;
    frames_expected--;
    #1;
    check("async_reset_line", bus.o_tx, 1);
    check("async_reset_busy", bus.o_tx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cycle();
    send(8'h3C);
    wait_done();

    // Parity corner bytes
    send(8'h07);
    wait_done();
    send(8'h03);
    wait_done();

    // Random bytes, random gaps, occasional ignored starts while busy
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks($urandom_range(1, FRAME - 20));
        if (bus.o_tx_busy) begin
          bus.i_tx_data = 8'($urandom);
          bus.i_tx_start = 1'b1;
          wait_cycle();
          bus.i_tx_start = 1'b0;
        end
      end
      wait_done();
      repeat ($urandom_range(0, 10)) wait_cycle();
    end

    repeat (50) wait_cycle();
    check("stray_done", stray_done, 0);
    check("queue_drained", exp_q.size(), 0);
    check("frames_completed", frames_done, frames_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
